sq_opn_pg_mux: RTL and testbench
================================

Name: sq_opn_pg_mux

Overview:
- Time-multiplexed OPN phase generator.
- Serves SLOTS operator slots round-robin, one slot per enabled cycle. Each slot has its own fnumber/block/multiple/key-on register set.
- Keeps one PHASE_W-bit phase accumulator per slot. Streams the truncated phase of each slot to the downstream sine/log table stage.
- Replaces the single fixed-parameter slot phase path with a register-programmable, multi-slot, key-on-aware generator.

Parameters:
SLOTS, 24, number of operator slots served per frame (2..32)
PHASE_W, 20, accumulator width; increment is masked to this width
OUT_W, 10, output phase width (top OUT_W bits of accumulator)
AW, 5, slot address width; must satisfy 2**AW >= SLOTS

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
en  in  1  clock enable (prescaled sample tick); pipeline advances only when high
wr_en  in  1  register write strobe, one cycle
wr_addr  in  AW  target slot
wr_data  in  19  {key_on[18], multiple[17:14], block[13:11], fnumber[10:0]}
out_valid  out  1  out_phase/out_slot valid this cycle
out_slot  out  AW  slot index of out_phase
out_phase  out  OUT_W  accumulator[PHASE_W-1 -: OUT_W] after update
out_sync  out  1  high with out_valid when out_slot==0 (frame start)

Behaviour:
- Reset (async, reset_n low): all configs, phases, key_seen flags, slot counter and pipeline registers clear to 0. out_valid, out_slot, out_phase and out_sync are 0.
- Writes:
  - Accepted on any cycle with wr_en=1, regardless of en.
  - wr_addr >= SLOTS is ignored, with no side effect.
  - A write lands at the clock edge.
  - If wr_en coincides with stage 1 reading the same slot, stage 1 uses the old value. The new value applies from that slot's next visit.
- Slot counter cnt: advances 0..SLOTS-1 on en. Wraps from SLOTS-1 to 0.
- Stage 1 (on en): registers s1_slot=cnt and s1_valid=1.
  - Increment: inc = ((fnumber << block) >> 1), 17 bits.
  - multiple==0 gives inc>>1; otherwise inc*multiple, 21 bits. Mask to PHASE_W.
  - restart = key_on & ~key_seen[cnt]. Then key_seen[cnt] <= key_on.
- Stage 2 (on en):
  - phase[s1_slot] <= restart ? 0 : (phase + inc) mod 2**PHASE_W.
  - out_phase <= top OUT_W bits of the new value; out_slot <= s1_slot.
  - out_valid <= s1_valid; out_sync <= s1_valid & (s1_slot==0).
- Latency: slot k is output 2 enabled cycles after cnt==k.
- Key-on and key-off:
  - Restart output is exactly 0 on the first visit after a key-on rising edge.
  - Holding key_on high does not restart again.
  - Key-off simply clears key_seen; the phase keeps running.
- en low:
  - All pipeline state holds, and out_valid is driven 0 that cycle.
  - out_phase and out_slot hold their last values.
- Wrap-around: the accumulator wraps silently modulo 2**PHASE_W, with no saturation.
- Start-up: the first two enabled cycles after reset emit out_valid=0 (pipeline fill).

Decomposition:
- Shared package sq_opn_pkg:
  - field offsets of wr_data (FNUM_LSB=0, BLK_LSB=11, MUL_LSB=14, KON_BIT=18);
  - FNUM_W=11, BLK_W=3, MUL_W=4;
  - function phase_inc(fnumber, block, multiple) returning the 21-bit increment.
- One natural sub-module: sq_opn_pg_inc, a combinational increment calculator used by stage 1. It is reusable by the future detune stage.
- Register file and accumulator array live in the top.

Test Plan:
- Single slot: slot 0 gets fnumber=0x100, block=0, mul=1, key_on=1; en always high.
  - inc=0x80. First visit outputs 0 (restart).
  - Visit n outputs out_phase=(n*0x80)>>10; visit 8 gives out_phase=1.
- mul=0 halves the rate: slot 1 gets fnumber=0x100, mul=0, key_on=1. The accumulator after 16 visits is 0x400 and out_phase=1.
- Max and wrap: slot 2 gets fnumber=0x7FF, block=7, mul=15.
  - inc=0x1DFC40, masked to 0xDFC40.
  - Accumulator visits give 0, 0xDFC40, then 0xBF880 (wrapped); out_phase=0x2FE.
- Key-on retrigger: key_on 1→0→1 mid-run. The phase resets to 0 exactly on the first visit after the second write. Holding key_on high causes no further reset.
- Write collision: write slot 3 in the cycle cnt==3. The old increment is used this frame and the new one from the next frame. A write to addr 31 (SLOTS=24) changes nothing.
- en gating and reset: en toggled 1/0.
  - out_valid follows en with 2-cycle pipeline alignment, and out_sync pulses once per SLOTS enabled cycles.
  - Async reset_n low mid-frame clears all outputs immediately. After release, slot 0 is the first valid output, on the 3rd enabled cycle.

Source files
------------

// File: rtl/sq_opn_pkg.sv
`default_nettype none
// ============================================================================
// sq_opn_pkg : wr_data field layout and phase increment helper for the OPN
//              phase generator.
// Rev 1.0
// ============================================================================
package sq_opn_pkg;

    localparam int FNUM_LSB = 0;
    localparam int BLK_LSB  = 11;
    localparam int MUL_LSB  = 14;
    localparam int KON_BIT  = 18;

    localparam int FNUM_W   = 11;
    localparam int BLK_W    = 3;
    localparam int MUL_W    = 4;
    localparam int CFG_W    = 19;
    localparam int BASE_W   = 17;
    localparam int INC_W    = 21;

    // multiple==0 means x0.5; otherwise x1..x15 on the block-shifted fnumber.
    function automatic logic [INC_W-1:0] phase_inc(
        input logic [FNUM_W-1:0] fnumber,
        input logic [BLK_W-1:0]  block,
        input logic [MUL_W-1:0]  multiple
    );
        logic [BASE_W:0]    shifted;
        logic [BASE_W-1:0]  base;
        logic [INC_W-1:0]   result;
        shifted = {7'b0, fnumber} << block;
        base    = BASE_W'(shifted >> 1);
        if (multiple == '0) begin
            result = INC_W'(base >> 1);
        end else begin
            result = INC_W'(base) * INC_W'(multiple);
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sq_opn_pg_inc.sv
`default_nettype none
// ============================================================================
// sq_opn_pg_inc : combinational phase increment, masked to the accumulator width.
// Rev 1.0
// ============================================================================
module sq_opn_pg_inc
    import sq_opn_pkg::*;
#(
    parameter int PHASE_W = 20
) (
    input  logic [FNUM_W-1:0]  fnumber,
    input  logic [BLK_W-1:0]   block,
    input  logic [MUL_W-1:0]   multiple,
    output logic [PHASE_W-1:0] inc
);

    logic [INC_W-1:0] w_full;

    assign w_full = phase_inc(fnumber, block, multiple);

    generate
        if (PHASE_W < INC_W) begin : g_trunc
            logic w_unused_hi;
            assign w_unused_hi = ^w_full[INC_W-1:PHASE_W];
            assign inc         = w_full[PHASE_W-1:0];
        end else begin : g_wide
            assign inc = PHASE_W'(w_full);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/sq_opn_pg_mux.sv
`default_nettype none
// ============================================================================
// sq_opn_pg_mux : time-multiplexed multi-slot OPN phase generator (2-stage pipe).
// Rev 1.0
// ============================================================================
module sq_opn_pg_mux
    import sq_opn_pkg::*;
#(
    parameter int SLOTS   = 24,
    parameter int PHASE_W = 20,
    parameter int OUT_W   = 10,
    parameter int AW      = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [CFG_W-1:0] wr_data,
    output logic             out_valid,
    output logic [AW-1:0]    out_slot,
    output logic [OUT_W-1:0] out_phase,
    output logic             out_sync
);

    localparam logic [AW:0]   c_slots = (AW+1)'(SLOTS);
    localparam logic [AW-1:0] c_last  = AW'(SLOTS - 1);

    logic [CFG_W-1:0]   r_cfg [SLOTS];
    logic [PHASE_W-1:0] r_phase [SLOTS];
    logic [SLOTS-1:0]   r_key_seen;
    logic [AW-1:0]      r_cnt;

    logic [AW-1:0]      r_s1_slot;
    logic               r_s1_valid;
    logic [PHASE_W-1:0] r_s1_inc;
    logic               r_s1_restart;

    logic               r_out_valid;
    logic [AW-1:0]      r_out_slot;
    logic [OUT_W-1:0]   r_out_phase;
    logic               r_out_sync;

    logic [CFG_W-1:0]   w_cfg;
    logic [FNUM_W-1:0]  w_fnum;
    logic [BLK_W-1:0]   w_blk;
    logic [MUL_W-1:0]   w_mul;
    logic               w_kon;
    logic               w_restart;
    logic [PHASE_W-1:0] w_inc;
    logic [PHASE_W-1:0] w_sum;
    logic [PHASE_W-1:0] w_new;
    logic               w_s2_go;

    // Register file: a same-cycle write to the slot being read lands after the read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SLOTS; i++) begin
                r_cfg[i] <= '0;
            end
        end else if (wr_en && ({1'b0, wr_addr} < c_slots)) begin
            r_cfg[wr_addr] <= wr_data;
        end
    end

    assign w_cfg     = r_cfg[r_cnt];
    assign w_fnum    = w_cfg[FNUM_LSB +: FNUM_W];
    assign w_blk     = w_cfg[BLK_LSB +: BLK_W];
    assign w_mul     = w_cfg[MUL_LSB +: MUL_W];
    assign w_kon     = w_cfg[KON_BIT];
    assign w_restart = w_kon & ~r_key_seen[r_cnt];

    sq_opn_pg_inc #(
        .PHASE_W  (PHASE_W)
    ) u_inc (
        .fnumber  (w_fnum),
        .block    (w_blk),
        .multiple (w_mul),
        .inc      (w_inc)
    );

    // Stage 1: slot sequencing, increment lookup and key-on edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt        <= '0;
            r_key_seen   <= '0;
            r_s1_slot    <= '0;
            r_s1_valid   <= 1'b0;
            r_s1_inc     <= '0;
            r_s1_restart <= 1'b0;
        end else if (en) begin
            r_cnt             <= (r_cnt == c_last) ? '0 : r_cnt + 1'b1;
            r_key_seen[r_cnt] <= w_kon;
            r_s1_slot         <= r_cnt;
            r_s1_valid        <= 1'b1;
            r_s1_inc          <= w_inc;
            r_s1_restart      <= w_restart;
        end
    end

    assign w_s2_go = en & r_s1_valid;
    assign w_sum   = r_phase[r_s1_slot] + r_s1_inc;
    assign w_new   = r_s1_restart ? '0 : w_sum;

    // Stage 2: accumulate; a slot is revisited only SLOTS cycles later, so no bypass.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SLOTS; i++) begin
                r_phase[i] <= '0;
            end
        end else if (w_s2_go) begin
            r_phase[r_s1_slot] <= w_new;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0;
            r_out_sync  <= 1'b0;
            r_out_slot  <= '0;
            r_out_phase <= '0;
        end else begin
            r_out_valid <= w_s2_go;
            r_out_sync  <= w_s2_go & (r_s1_slot == '0);
            if (w_s2_go) begin
                r_out_slot  <= r_s1_slot;
                r_out_phase <= w_new[PHASE_W-1 -: OUT_W];
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_slot  = r_out_slot;
    assign out_phase = r_out_phase;
    assign out_sync  = r_out_sync;

endmodule
`default_nettype wire

// File: tb/tb_sq_opn_pg_mux.sv
`default_nettype none
// ============================================================================
// tb_sq_opn_pg_mux : scoreboard bench for the multi-slot OPN phase generator.
// Rev 1.0
// ============================================================================
module tb_sq_opn_pg_mux;

    localparam int SLOTS = 24;
    localparam int PW    = 20;
    localparam int OW    = 10;
    localparam int AW    = 5;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          en;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [18:0]   wr_data;
    logic          out_valid;
    logic [AW-1:0] out_slot;
    logic [OW-1:0] out_phase;
    logic          out_sync;

    always #5 clk = ~clk;

    sq_opn_pg_mux #(
        .SLOTS     (SLOTS),
        .PHASE_W   (PW),
        .OUT_W     (OW),
        .AW        (AW)
    ) u_dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .en        (en),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .out_valid (out_valid),
        .out_slot  (out_slot),
        .out_phase (out_phase),
        .out_sync  (out_sync)
    );

    typedef struct packed {
        logic [AW-1:0] slot;
        logic [OW-1:0] ph;
    } exp_t;

    int            vectors    = 0;
    int            miscompares = 0;

    exp_t          sb[$];
    logic [18:0]   m_cfg   [SLOTS];
    logic [PW-1:0] m_ph    [SLOTS];
    bit            m_ks    [SLOTS];
    int            m_visit [SLOTS];
    int            m_cnt;
    bit            m_s1v;
    bit            m_exp_valid;
    logic [AW-1:0] m_last_slot;
    logic [OW-1:0] m_last_ph;
    bit            ex_on;
    logic [OW-1:0] s2_tab [3] = '{10'h000, 10'h37F, 10'h2FE};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [PW-1:0] model_inc(input logic [18:0] c);
        logic [63:0] f, b, m, base, i;
        f    = 64'(c[10:0]);
        b    = 64'(c[13:11]);
        m    = 64'(c[17:14]);
        base = (f << b) >> 1;
        i    = (m == 0) ? (base >> 1) : (base * m);
        return i[PW-1:0];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < SLOTS; i++) begin
            m_cfg[i]   = '0;
            m_ph[i]    = '0;
            m_ks[i]    = 1'b0;
            m_visit[i] = 0;
        end
        sb.delete();
        m_cnt       = 0;
        m_s1v       = 1'b0;
        m_exp_valid = 1'b0;
        m_last_slot = '0;
        m_last_ph   = '0;
    endtask

    // Predicts the effect of the coming clock edge from current inputs.
    task automatic model_step();
        logic [18:0] c;
        bit          rs;
        if (!reset_n) begin
            model_clear();
            return;
        end
        if (en) begin
            c            = m_cfg[m_cnt];
            rs           = c[18] && !m_ks[m_cnt];
            m_ks[m_cnt]  = c[18];
            m_ph[m_cnt]  = rs ? '0 : m_ph[m_cnt] + model_inc(c);
            m_exp_valid  = m_s1v;
            m_s1v        = 1'b1;
            sb.push_back('{slot: AW'(m_cnt), ph: m_ph[m_cnt][PW-1 -: OW]});
            m_cnt        = (m_cnt == SLOTS - 1) ? 0 : m_cnt + 1;
        end else begin
            m_exp_valid  = 1'b0;
        end
        if (wr_en && (int'(wr_addr) < SLOTS)) begin
            m_cfg[wr_addr] = wr_data;
        end
    endtask

    task automatic monitor();
        exp_t e;
        int   v;
        if (m_exp_valid) begin
            chk("sb_nonempty", 32'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                e           = sb.pop_front();
                m_last_slot = e.slot;
                m_last_ph   = e.ph;
                v           = m_visit[e.slot];
                m_visit[e.slot]++;
                if (ex_on) begin
                    if (e.slot == 0 && v == 8)  chk("s0_visit8", out_phase, 1);
                    if (e.slot == 1 && v == 16) chk("s1_mul0_visit16", out_phase, 1);
                    if (e.slot == 2 && v < 3)   chk("s2_wrap", out_phase, s2_tab[v]);
                end
            end
        end
        chk("out_valid", out_valid, m_exp_valid);
        chk("out_sync",  out_sync,  m_exp_valid && (m_last_slot == 0));
        chk("out_slot",  out_slot,  m_last_slot);
        chk("out_phase", out_phase, m_last_ph);
    endtask

    task automatic cycle(input bit rn, input bit e, input bit we,
                         input logic [AW-1:0] a, input logic [18:0] d);
        @(negedge clk);
        monitor();
        #1;
        if (!rn && reset_n) begin
            reset_n = 1'b0;
            #1;
            chk("rst_valid", out_valid, 0);
            chk("rst_sync",  out_sync,  0);
            chk("rst_slot",  out_slot,  0);
            chk("rst_phase", out_phase, 0);
        end
        reset_n = rn;
        en      = e;
        wr_en   = we;
        wr_addr = a;
        wr_data = d;
        model_step();
    endtask

    initial begin
        bit            we;
        logic [AW-1:0] a;
        logic [18:0]   d;
        reset_n = 1'b0;
        en      = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        ex_on   = 1'b1;
        model_clear();
        repeat (3) cycle(0, 0, 0, '0, '0);

        // Configure with en low; writes must still land.
        cycle(1, 0, 1, 5'd0, {1'b1, 4'd1,  3'd0, 11'h100});
        cycle(1, 0, 1, 5'd1, {1'b1, 4'd0,  3'd0, 11'h100});
        cycle(1, 0, 1, 5'd2, {1'b1, 4'd15, 3'd7, 11'h7FF});
        cycle(1, 0, 1, 5'd3, {1'b1, 4'd2,  3'd1, 11'h0C0});
        cycle(1, 0, 1, 5'd4, {1'b1, 4'd3,  3'd2, 11'h155});
        cycle(1, 0, 1, 5'd9, {1'b1, 4'd5,  3'd4, 11'h3A1});
        cycle(1, 0, 0, '0, '0);

        for (int i = 0; i < 17 * SLOTS + 4; i++) begin
            we = 1'b0; a = '0; d = '0;
            if (i == 5 * SLOTS + 3) begin
                we = 1'b1; a = 5'd3;  d = {1'b1, 4'd7, 3'd3, 11'h2AB};
            end else if (i == 6 * SLOTS + 1) begin
                we = 1'b1; a = 5'd4;  d = {1'b0, 4'd3, 3'd2, 11'h155};
            end else if (i == 7 * SLOTS + 5) begin
                we = 1'b1; a = 5'd31; d = '1;
            end else if (i == 9 * SLOTS + 20) begin
                we = 1'b1; a = 5'd4;  d = {1'b1, 4'd3, 3'd2, 11'h155};
            end
            cycle(1, 1, we, a, d);
        end
        ex_on = 1'b0;

        for (int i = 0; i < 300; i++) begin
            we = ($urandom_range(0, 7) == 0);
            a  = AW'($urandom_range(0, 31));
            d  = 19'($urandom);
            cycle(1, bit'($urandom_range(0, 1)), we, a, d);
        end

        repeat (3) cycle(0, 1, 0, '0, '0);
        for (int i = 0; i < 80; i++) begin
            cycle(1, (i % 3) != 1, 1'b0, '0, '0);
        end
        repeat (4) cycle(1, 0, 0, '0, '0);
        chk("sb_residue", 32'(sb.size() <= 1), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
